// File: rtl/apb_master.sv
// Single-outstanding APB initiator: valid/ready request in, SETUP/ACCESS
// transfer on the bus, one-cycle response out, with a wait-state timeout.
module apb_master #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              pclk_i,
   input  logic              rst_n_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_write_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              rsp_timeout_o,
   output logic              busy_o,
   output logic              psel_o,
   output logic              penable_o,
   output logic              pwrite_o,
   output logic [ADDR_W-1:0] paddr_o,
   output logic [DATA_W-1:0] pwdata_o,
   input  logic [DATA_W-1:0] prdata_i,
   input  logic              pready_i,
   input  logic              pslverr_i
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic          accept;
   logic          done;
   logic          abort;

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      done      = 1'b0;
      abort     = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_valid_i && req_ready_o) begin
               accept    = 1'b1;
               state_nxt = SETUP;
            end
         end
         SETUP: state_nxt = ACCESS;
         ACCESS: begin
            // a slave answering on the last allowed cycle still completes
            if (pready_i) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end else if (TIMEOUT != 0 && cnt == LAST) begin
               abort     = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge pclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge pclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         req_ready_o   <= 1'b0;
         rsp_valid_o   <= 1'b0;
         rsp_err_o     <= 1'b0;
         rsp_timeout_o <= 1'b0;
         rsp_rdata_o   <= '0;
         pwrite_o      <= 1'b0;
         paddr_o       <= '0;
         pwdata_o      <= '0;
         cnt           <= '0;
      end else begin
         req_ready_o <= (state_nxt == IDLE);
         rsp_valid_o <= done | abort;
         if (accept) begin
            pwrite_o <= req_write_i;
            paddr_o  <= req_addr_i;
            pwdata_o <= req_wdata_i;
         end
         if (state == SETUP) begin
            cnt <= '0;
         end else if (state == ACCESS && !pready_i && !abort) begin
            cnt <= cnt + 1'b1;
         end
         if (done) begin
            rsp_err_o     <= pslverr_i;
            rsp_timeout_o <= 1'b0;
            rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
         end else if (abort) begin
            rsp_err_o     <= 1'b1;
            rsp_timeout_o <= 1'b1;
            rsp_rdata_o   <= '0;
         end
      end
   end

   assign psel_o    = (state != IDLE);
   assign penable_o = (state == ACCESS);
   assign busy_o    = (state != IDLE);

endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB initiator that turns a simple valid/ready request into a compliant APB SETUP/ACCESS transfer and returns a one-cycle response with read data and error status. Sits between a command source (sequencer, debug bridge, CPU-side port) and APB slaves such as `interrupt_controller`, and is the master-side counterpart of their `psel`/`penable`/`pready` interface. Includes a programmable wait-state timeout so a hung slave cannot stall the requester.

## Interface
- `ADDR_W`, 32, width of `paddr_o` / `req_addr_i`
- `DATA_W`, 32, width of the write and read data paths
- `TIMEOUT`, 16, maximum ACCESS cycles per transfer; 0 disables the timeout

- `pclk_i`  in  1  clock; the block has one clock, all logic on its rising edge
- `rst_n_i`  in  1  reset, asynchronous assert, active-low
- `req_valid_i`  in  1  request present
- `req_ready_o`  out  1  block can accept a request (registered)
- `req_write_i`  in  1  1 = write, 0 = read
- `req_addr_i`  in  ADDR_W  transfer address
- `req_wdata_i`  in  DATA_W  write data
- `rsp_valid_o`  out  1  one-cycle response strobe
- `rsp_rdata_o`  out  DATA_W  read data; 0 for writes and timeouts
- `rsp_err_o`  out  1  slave error or timeout, valid with `rsp_valid_o`
- `rsp_timeout_o`  out  1  error caused by timeout, valid with `rsp_valid_o`
- `busy_o`  out  1  transfer in progress (state != IDLE)
- `psel_o`, `penable_o`, `pwrite_o`  out  1  APB controls
- `paddr_o`  out  ADDR_W;  `pwdata_o`  out  DATA_W  APB address/write data
- `prdata_i`  in  DATA_W;  `pready_i`, `pslverr_i`  in  1  APB slave response

## Operation
- FSM states: IDLE, SETUP, ACCESS. Reset state IDLE.
- IDLE: request accepted when `req_valid_i && req_ready_o`; `req_write_i`, `req_addr_i`, `req_wdata_i` captured into registers driving `pwrite_o`, `paddr_o`, `pwdata_o`; next state SETUP.
- SETUP: `psel_o`=1, `penable_o`=0; unconditional move to ACCESS; wait counter cleared.
- ACCESS: `psel_o`=1, `penable_o`=1. If `pready_i`=1: complete, next IDLE. Else if `TIMEOUT`!=0 and counter == `TIMEOUT`-1: abort, next IDLE. Else counter increments, remain.
- Completion: `rsp_err_o` = `pslverr_i`, `rsp_timeout_o`=0, `rsp_rdata_o` = `prdata_i` for reads, 0 for writes. `prdata_i`/`pslverr_i` are sampled only in the ACCESS cycle with `pready_i`=1.
- Abort: `rsp_err_o`=1, `rsp_timeout_o`=1, `rsp_rdata_o`=0.
- `paddr_o`, `pwrite_o`, `pwdata_o` are stable from SETUP through the final ACCESS cycle; in IDLE they hold the last transfer's values.
- `req_ready_o` register next value = (next_state == IDLE). Only one transfer is outstanding.
- Counter width is clog2(`TIMEOUT`+1); it never wraps, because the abort fires first.

## Timing
- Reset (asynchronous, immediate): `psel_o`, `penable_o`, `pwrite_o`, `busy_o`, `req_ready_o`, `rsp_valid_o`, `rsp_err_o`, `rsp_timeout_o` = 0; `paddr_o`, `pwdata_o`, `rsp_rdata_o` = 0.
- `req_ready_o` rises on the first `pclk_i` edge after `rst_n_i` deasserts.
- Accept at cycle N (IDLE): SETUP at N+1, first ACCESS at N+2.
- Zero wait states: `pready_i`=1 at N+2. At N+3 the block is in IDLE, `rsp_valid_o`=1 for exactly one cycle, and `req_ready_o`=1. A new request accepted at N+3 gives the next SETUP at N+4, so a back-to-back transfer takes 3 cycles.
- W wait states: the response arrives at N+3+W.
- Timeout: `TIMEOUT` ACCESS cycles with `pready_i`=0. `psel_o`/`penable_o` drop and the response strobes at N+2+`TIMEOUT`.
- `pready_i` high in the same cycle the counter hits its limit: completion wins and there is no timeout.
- Reset during SETUP/ACCESS: the bus is released immediately, no response is issued, and the in-flight request is lost.
- `req_valid_i` while not ready: ignored; the requester holds it until the handshake.

## Test plan
- Reset then write 0x0000_0004 ← 0xDEAD_BEEF, `pready_i` tied 1 -> SETUP/ACCESS on cycles N+1/N+2, `paddr_o`=0x4, `pwdata_o`=0xDEADBEEF, `pwrite_o`=1, `rsp_valid_o` at N+3, `rsp_err_o`=0, `rsp_rdata_o`=0.
- Read 0x8 with 3 wait states, `prdata_i`=0x0000_000F when `pready_i` rises -> `penable_o` high 4 cycles, address stable throughout, `rsp_rdata_o`=0xF at N+6.
- Read with `pslverr_i`=1 on the ready cycle -> `rsp_err_o`=1, `rsp_timeout_o`=0; `pslverr_i` toggling during wait states has no effect.
- `TIMEOUT`=4, `pready_i` stuck 0 -> exactly 4 ACCESS cycles, then `psel_o`=0, `rsp_valid_o`/`rsp_err_o`/`rsp_timeout_o`=1, `rsp_rdata_o`=0; repeat with `pready_i`=1 on the 4th ACCESS cycle -> normal completion.
- Two back-to-back requests with `req_valid_i` held high -> second SETUP exactly 3 cycles after the first, both responses correct; `req_ready_o` low in SETUP/ACCESS.
- `rst_n_i` asserted mid-ACCESS -> `psel_o`/`penable_o` drop asynchronously, no `rsp_valid_o`; after release, `req_ready_o`=1 one cycle later and the next transfer completes normally.
